// File: rtl/fpu_issue_sequencer.sv
// fpu_issue_sequencer
// Dispatches FPU ops to the functional unit chosen by unit_sel and returns
// their results strictly in issue order over one valid/ready writeback port.
// An order FIFO of unit ids tracks which unit owns the oldest in-flight op.
// Issue and retire are combinational pass-throughs (zero added latency); only
// the FIFO contents, pointers and occupancy are stored.
module fpu_issue_sequencer #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 4,
    localparam int UW       = $clog2(NUM_UNITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [UW-1:0]           unit_sel,
    output logic [NUM_UNITS-1:0]    unit_valid_in,
    input  logic [NUM_UNITS-1:0]    unit_ready_out,
    input  logic [NUM_UNITS-1:0]    unit_valid_out,
    output logic [NUM_UNITS-1:0]    unit_ready_in,
    input  logic [32*NUM_UNITS-1:0] unit_result,
    input  logic [5*NUM_UNITS-1:0]  unit_fflags,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [31:0]             result,
    output logic [4:0]              fflags
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Order FIFO: one unit id per in-flight op, oldest at rd_ptr_r.
    logic [UW-1:0] fifo_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          empty_s;
    logic          full_s;
    logic [UW-1:0] head_s;
    logic          head_valid_s;
    logic [31:0]   head_result_s;
    logic [4:0]    head_fflags_s;
    logic          sel_ready_s;
    logic          push_s;
    logic          pop_s;

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CW'(DEPTH));
    assign head_s  = fifo_r[rd_ptr_r];

    // Select the head unit's result handshake/payload and the target unit's
    // readiness. Looping over legal ids means an out-of-range unit_sel never
    // matches, so it reads as "not ready" and can never be accepted.
    always_comb begin
        head_valid_s  = 1'b0;
        head_result_s = 32'd0;
        head_fflags_s = 5'd0;
        sel_ready_s   = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            head_valid_s  = (head_s == UW'(i))   ? unit_valid_out[i]     : head_valid_s;
            head_result_s = (head_s == UW'(i))   ? unit_result[32*i +: 32] : head_result_s;
            head_fflags_s = (head_s == UW'(i))   ? unit_fflags[5*i +: 5]   : head_fflags_s;
            sel_ready_s   = (unit_sel == UW'(i)) ? unit_ready_out[i]     : sel_ready_s;
        end
    end

    // Retire side: only the head unit may present a result; everything is
    // squashed while flushing or when nothing is in flight.
    always_comb begin
        valid_out = !flush && !empty_s && head_valid_s;
        pop_s     = valid_out && ready_in;
        result    = valid_out ? head_result_s : 32'd0;
        fflags    = valid_out ? head_fflags_s : 5'd0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_ready_in[i] = ready_in && !empty_s && !flush && (head_s == UW'(i));
        end
    end

    // Issue side: a same-cycle pop frees a slot when full, so ready_out
    // depends combinationally on ready_in. Held low while reset is asserted.
    always_comb begin
        ready_out = !reset && !flush && sel_ready_s && (!full_s || pop_s);
        push_s    = valid_in && ready_out;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_valid_in[i] = push_s && (unit_sel == UW'(i));
        end
    end

    // Order FIFO storage, pointers and occupancy; flush empties it at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {UW{1'b0}};
            end
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= unit_sel;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
